platform_button_ctrl: RTL and testbench

Debouncing, edge-capturing interrupt controller for the board push-buttons on the platform's Avalon-MM peripheral bus. It synchronises and debounces WIDTH raw button inputs and latches rising edges into a sticky capture register. It raises a level interrupt to the processor for unmasked captured edges. It replaces direct software polling of the raw button PIO and sits between the button pins and the CPU interrupt controller.

---
 rtl/platform_button_pkg.sv | 12 +
 rtl/platform_button_debounce.sv | 55 +++++
 rtl/platform_button_ctrl.sv | 85 ++++++++
 tb/tb_platform_button_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/platform_button_pkg.sv
// Shared constants for the push-button interrupt controller.
// Register addresses and bus width live here.
package platform_button_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

endpackage

// File: rtl/platform_button_debounce.sv
// One-bit synchroniser and debouncer for a push-button input.
// Emits the synchronised level, debounced level and a rise pulse.
module platform_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync2,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          stable_q;
  logic [CW-1:0] cnt;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip when the count completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CMAX) begin
      cnt    <= '0;
      stable <= ~stable;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) stable_q <= 1'b0;
    else       stable_q <= stable;
  end

  assign rise = stable & ~stable_q;

endmodule

// File: rtl/platform_button_ctrl.sv
// Avalon-MM button controller: debounce, edge capture and irq.
// Register file and interrupt logic around per-bit debouncers.
module platform_button_ctrl
  import platform_button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [BUS_W-1:0] writedata,
  output logic [BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wr_bits;
  logic [BUS_W-1:0] rd_mux;
  logic             wr_en;
  logic             unused_wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    platform_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[i]),
      .sync2 (sync2[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  assign wr_en     = chipselect & ~write_n;
  assign wr_bits   = writedata[WIDTH-1:0];
  assign unused_wr = ^writedata;

  // Interrupt mask register.
  always_ff @(posedge clk) begin
    if (reset)
      irq_mask <= '0;
    else if (wr_en && address == ADDR_MASK)
      irq_mask <= wr_bits;
  end

  // Sticky rising-edge capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)
      edge_capture <= '0;
    else if (wr_en && address == ADDR_EDGE)
      edge_capture <= (edge_capture & ~wr_bits) | rise;
    else
      edge_capture <= edge_capture | rise;
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_RAW:  rd_mux[WIDTH-1:0] = sync2;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_platform_button_ctrl.sv
// Directed bench for platform_button_ctrl, 4 bits, 4-cycle debounce.
// Inputs change 1 time unit after rising edges; checks follow likewise.
module tb_platform_button_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int tests = 0;
  int fails = 0;

  platform_button_ctrl #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'h0;

    // reset state
    tick(2);
    check("rst_rd", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    rd("rst_data", 2'd0, 32'h0);
    rd("rst_raw", 2'd1, 32'h0);
    rd("rst_mask", 2'd2, 32'h0);
    rd("rst_edge", 2'd3, 32'h0);

    // clean press on bit 0: stable at edge 6, visible edge 7
    address = 2'd0;
    in_port = 4'h1;
    tick(2);
    tick();
    check("raw_lat", readdata, 32'h0);
    rd("raw_bit0", 2'd1, 32'h1);
    address = 2'd0;
    tick(2);
    check("press_pre", readdata, 32'h0);
    tick();
    check("press_data", readdata, 32'h1);
    check("press_irq0", {31'b0, irq}, 32'h0);
    rd("press_edge", 2'd3, 32'h1);
    check("press_irq_m0", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    check("mask_irq", {31'b0, irq}, 32'h1);
    rd("mask_rd", 2'd2, 32'h1);

    // bounce on bit 1: 3 high, 1 low, then held
    address = 2'd0;
    in_port = 4'h3;
    tick(3);
    in_port = 4'h1;
    tick();
    in_port = 4'h3;
    tick(6);
    check("bounce_pre", readdata, 32'h1);
    tick();
    check("bounce_data", readdata, 32'h3);
    rd("bounce_edge", 2'd3, 32'h3);

    // write-one-to-clear
    wr(2'd2, 32'h3);
    check("w1c_irq_a", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("w1c_irq_b", {31'b0, irq}, 32'h1);
    rd("w1c_edge_a", 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    check("w1c_irq_c", {31'b0, irq}, 32'h0);
    rd("w1c_edge_b", 2'd3, 32'h0);

    // clear of bit 2 on the same edge its capture sets
    in_port = 4'h7;
    tick(6);
    wr(2'd3, 32'h4);
    rd("sim_edge", 2'd3, 32'h4);
    check("sim_irq", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h0);
    rd("w0_noeffect", 2'd3, 32'h4);
    wr(2'd0, 32'hF);
    rd("ro_data", 2'd0, 32'h7);
    wr(2'd3, 32'h4);
    rd("w1c_bit2", 2'd3, 32'h0);

    // falling edges are not captured
    in_port = 4'h0;
    tick(8);
    rd("fall_edge", 2'd3, 32'h0);
    rd("fall_data", 2'd0, 32'h0);
    check("fall_irq", {31'b0, irq}, 32'h0);

    // reset in the middle of a debounce count on bit 3
    address = 2'd0;
    in_port = 4'h8;
    tick(4);
    reset = 1'b1;
    tick(2);
    check("mid_rst_rd", readdata, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    tick(6);
    check("mid_pre", readdata, 32'h0);
    tick();
    check("mid_data", readdata, 32'h8);
    rd("mid_mask", 2'd2, 32'h0);
    rd("mid_edge", 2'd3, 32'h8);
    wr(2'd2, 32'h8);
    check("mid_irq", {31'b0, irq}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
